// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 11;  // start + 8 data + parity + stop
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit, mid-bit sampling.
// Handshake: rx_done is a one-cycle strobe with no back-pressure; data_out and the error flags are valid with it and held until the next strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  data_out,
  output logic        rx_done,
  output logic        parity_err,
  output logic        frame_err,
  output uart_state_e dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_tick;

  uart_state_e          r_state;
  uart_state_e          w_next_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift;
  logic                 r_par_acc;
  logic                 w_par_acc;
  logic                 r_par_err_pend;
  logic                 w_par_err_pend;
  logic [DATA_BITS-1:0] r_data_out;
  logic [DATA_BITS-1:0] w_data_out;
  logic                 r_rx_done;
  logic                 w_rx_done;
  logic                 r_parity_err;
  logic                 w_parity_err;
  logic                 r_frame_err;
  logic                 w_frame_err;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // The counter counts down to zero and reloads on every sample, so each bit is timed from its own sample point.
  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_next_state   = r_state;
    w_cnt          = r_cnt;
    w_bit_cnt      = r_bit_cnt;
    w_shift        = r_shift;
    w_par_acc      = r_par_acc;
    w_par_err_pend = r_par_err_pend;
    w_data_out     = r_data_out;
    w_parity_err   = r_parity_err;
    w_frame_err    = r_frame_err;
    w_rx_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_next_state = ST_START;
          w_bit_cnt    = '0;
          w_cnt        = HALF_RELOAD;
          w_par_acc    = 1'b0;
        end
      end

      ST_START: begin
        if (w_tick) begin
          if (!w_rx_s) begin
            w_next_state = ST_DATA;
            w_cnt        = FULL_RELOAD;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift   = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_par_acc = r_par_acc ^ w_rx_s;
          w_cnt     = FULL_RELOAD;
          if (r_bit_cnt == LAST_BIT) begin
            w_next_state = ST_PARITY;
          end else begin
            w_bit_cnt = r_bit_cnt + BW'(1);
          end
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end

      ST_PARITY: begin
        if (w_tick) begin
          w_par_err_pend = ((r_par_acc ^ w_rx_s) != PARITY_ODD);
          w_cnt          = FULL_RELOAD;
          w_next_state   = ST_STOP;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          w_data_out   = r_shift;
          w_parity_err = r_par_err_pend;
          w_frame_err  = ~w_rx_s;
          w_rx_done    = 1'b1;
          w_next_state = w_rx_s ? ST_IDLE : ST_BREAK;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end

      // A line held low after a bad stop bit must not be taken as a new start bit.
      ST_BREAK: begin
        if (w_rx_s) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_par_acc      <= 1'b0;
      r_par_err_pend <= 1'b0;
      r_data_out     <= '0;
      r_rx_done      <= 1'b0;
      r_parity_err   <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_cnt;
      r_bit_cnt      <= w_bit_cnt;
      r_shift        <= w_shift;
      r_par_acc      <= w_par_acc;
      r_par_err_pend <= w_par_err_pend;
      r_data_out     <= w_data_out;
      r_rx_done      <= w_rx_done;
      r_parity_err   <= w_parity_err;
      r_frame_err    <= w_frame_err;
    end
  end

  assign data_out   = r_data_out;
  assign rx_done    = r_rx_done;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: even- and odd-parity receivers share one serial line and are checked against a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int N = 16;
  localparam int H = N / 2;
  localparam int W = 42;  // {done cycle[31:0], data[7:0], parity_err, frame_err}

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] cyc;

  logic [7:0]  data_e, data_o;
  logic        done_e, done_o;
  logic        perr_e, perr_o;
  logic        ferr_e, ferr_o;
  uart_state_e st_e, st_o;

  logic [W-1:0] exp_q_e[$];
  logic [W-1:0] exp_q_o[$];
  logic [W-1:0] got_q_e[$];
  logic [W-1:0] got_q_o[$];
  logic [9:0]   last_e, last_o;

  int n_cmp;
  int n_bad;

  uart_rx #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) u_even (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_e),
    .rx_done    (done_e),
    .parity_err (perr_e),
    .frame_err  (ferr_e),
    .dbg_state  (st_e)
  );

  uart_rx #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b1)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_o),
    .rx_done    (done_o),
    .parity_err (perr_o),
    .frame_err  (ferr_o),
    .dbg_state  (st_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 32'd1;
  end

  // Completion monitor: one entry per cycle the strobe is seen high.
  always @(negedge clk) begin
    if (rst === 1'b1 && done_e === 1'b1) got_q_e.push_back({cyc, data_e, perr_e, ferr_e});
    if (rst === 1'b1 && done_o === 1'b1) got_q_o.push_back({cyc, data_o, perr_o, ferr_o});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: called just after a rising edge E. The pin is 2 flops from the FSM,
  // so the first edge seeing the start bit is t0 = E+3 and the strobe is seen in
  // the cycle after edge t0+H+10N.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
    logic [10:0] bits;
    logic [31:0] t_done;
    logic        pe_even, pe_odd;
    bits    = {sbit, pbit, d, 1'b0};
    t_done  = cyc + 32'(3 + H + 10 * N);
    pe_even = ((^d) ^ pbit) != 1'b0;
    pe_odd  = ((^d) ^ pbit) != 1'b1;
    exp_q_e.push_back({t_done, d, pe_even, ~sbit});
    exp_q_o.push_back({t_done, d, pe_odd,  ~sbit});
    last_e = {d, pe_even, ~sbit};
    last_o = {d, pe_odd,  ~sbit};
    for (int j = 0; j < FRAME_BITS; j++) begin
      rx = bits[j];
      idle(N);
    end
  endtask

  // Scoreboard: compare every recorded completion with the expected queue, then drain both.
  task automatic check_done(input string tag);
    int n;
    logic [W-1:0] g, e;
    chk({tag, "_count_even"}, 64'(got_q_e.size()), 64'(exp_q_e.size()));
    chk({tag, "_count_odd"},  64'(got_q_o.size()), 64'(exp_q_o.size()));
    n = (got_q_e.size() < exp_q_e.size()) ? got_q_e.size() : exp_q_e.size();
    for (int i = 0; i < n; i++) begin
      g = got_q_e.pop_front();
      e = exp_q_e.pop_front();
      chk({tag, "_even"}, 64'(g), 64'(e));
    end
    n = (got_q_o.size() < exp_q_o.size()) ? got_q_o.size() : exp_q_o.size();
    for (int i = 0; i < n; i++) begin
      g = got_q_o.pop_front();
      e = exp_q_o.pop_front();
      chk({tag, "_odd"}, 64'(g), 64'(e));
    end
    got_q_e.delete();
    got_q_o.delete();
    exp_q_e.delete();
    exp_q_o.delete();
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_held_even"}, 64'({data_e, perr_e, ferr_e}), 64'(last_e));
    chk({tag, "_held_odd"},  64'({data_o, perr_o, ferr_o}), 64'(last_o));
    chk({tag, "_idle_even"}, 64'(st_e), 64'(ST_IDLE));
    chk({tag, "_idle_odd"},  64'(st_o), 64'(ST_IDLE));
  endtask

  initial begin
    logic [7:0] d;
    logic       pbit;
    logic       sbit;
    n_cmp  = 0;
    n_bad  = 0;
    last_e = '0;
    last_o = '0;
    rx     = 1'b1;
    rst    = 1'b0;
    idle(4);

    // Reset values
    chk("rst_data",  64'(data_e), 64'h00);
    chk("rst_done",  64'(done_e), 64'h0);
    chk("rst_perr",  64'(perr_e), 64'h0);
    chk("rst_ferr",  64'(ferr_e), 64'h0);
    chk("rst_state", 64'(st_e),   64'(ST_IDLE));
    chk("rst_odd",   64'({data_o, done_o, perr_o, ferr_o}), 64'h0);
    rst = 1'b1;
    idle(5);

    // Clean 0xAC, even parity bit 0
    send_frame(8'hAC, 1'b0, 1'b1);
    idle(2 * N);
    check_done("clean_ac");
    check_held("clean_ac");

    // Flipped parity bit, then a clean frame clears the flag
    send_frame(8'hAC, 1'b1, 1'b1);
    idle(N);
    chk("bad_parity_flag", 64'(perr_e), 64'h1);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(N);
    check_done("parity");
    check_held("parity");

    // Bad stop bit, line held low for 3N, then a clean 0x01
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(3 * N);
    chk("break_even", 64'(st_e), 64'(ST_BREAK));
    chk("break_odd",  64'(st_o), 64'(ST_BREAK));
    rx = 1'b1;
    idle(4);
    check_done("break");
    check_held("break");
    send_frame(8'h01, 1'b1, 1'b1);
    idle(N);
    check_done("after_break");

    // Short low glitch is rejected
    rx = 1'b0;
    idle(N / 4);
    rx = 1'b1;
    idle(2 * N);
    check_done("glitch");
    check_held("glitch");

    // Reset during data bit 4 of 0xFF, then 0x81
    rx = 1'b0;
    idle(N);
    rx = 1'b1;
    idle(4 * N + H);
    rst = 1'b0;
    idle(3);
    last_e = '0;
    last_o = '0;
    chk("midrst_outputs", 64'({data_e, done_e, perr_e, ferr_e}), 64'h0);
    chk("midrst_state",   64'(st_e), 64'(ST_IDLE));
    rst = 1'b1;
    idle(3);
    check_done("midrst");
    send_frame(8'h81, 1'b0, 1'b1);
    idle(N);
    check_done("after_rst");

    // Back-to-back frames, parity bits correct for odd parity
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(N);
    check_done("b2b");

    // Random frames with random parity, stop bit and gaps
    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = (^d) ^ ($urandom_range(0, 1) == 1);
      sbit = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, sbit);
      if (!sbit) begin
        idle(N);
        rx = 1'b1;
        idle(4);
      end
      idle($urandom_range(0, 2 * N));
    end
    idle(N);
    check_done("random");
    check_held("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: recovers 8-bit frames (start, 8 data LSB-first, parity, 1 stop) from the `rx` line, checks parity and stop bit, and presents each byte with a one-cycle completion strobe. It is the receive half instantiated inside the UART top level, driven by the transmitter's `tx` line in loopback and by the external pin in the system.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per bit period; integer ≥ 4.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input; asynchronous to `clk`; idle high.
- `data_out`  out  8  last received byte; held until the next `rx_done`.
- `rx_done`  out  1  one-cycle pulse when a frame completes.
- `parity_err`  out  1  parity status of the last frame; updated with `rx_done`, held until the next one.
- `frame_err`  out  1  set when the last frame's stop bit sampled low; updated with `rx_done`, held until the next one.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1; FSM sees only `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on `rx_s` = 0 -> START, clear bit counter, load the half-bit count.
- START: after `CLKS_PER_BIT/2` cycles, sample `rx_s`. 0 -> DATA. 1 -> IDLE (glitch rejected; no `rx_done`, outputs unchanged).
- DATA: sample every `CLKS_PER_BIT` cycles into a shift register, LSB first; after the 8th sample -> PARITY.
- PARITY: sample one bit. `parity_err` = XOR(data, sampled bit) ≠ `PARITY_ODD`.
- STOP: sample one bit; register `data_out`, `parity_err`, `frame_err` = ~sample; pulse `rx_done`. Sample 1 -> IDLE. Sample 0 -> BREAK.
- BREAK: wait for `rx_s` = 1 -> IDLE. No new frame starts while the line is held low.
- The bit-period counter is sized to `$clog2(CLKS_PER_BIT)` and reloads on every sample. No drift accumulation.

## Timing
- Reset values: `data_out` = 0x00, `rx_done` = 0, `parity_err` = 0, `frame_err` = 0. FSM = IDLE. Synchronizer = 1.
- Let t0 be the first edge at which `rx_s` = 0 in IDLE. With H = `CLKS_PER_BIT/2` and N = `CLKS_PER_BIT`:
  - start sampled at t0+H;
  - data bit i (0..7) at t0+H+(i+1)·N;
  - parity at t0+H+9N;
  - stop at t0+H+10N.
- `rx_done`, `data_out` and the error flags update at t0+H+10N+1. `rx_done` is high for exactly one cycle.
- Pin-to-`rx_s` latency is 2 cycles.
- Back-to-back frames: a start edge arriving in the cycle IDLE is re-entered is accepted. The minimum frame spacing is 11N.
- `rst` asserted mid-frame: immediate return to IDLE with all outputs at reset values. A partial byte is never reported.

## Structure
- Shared `uart_pkg`:
  - state enum (IDLE..BREAK);
  - `DATA_BITS` = 8;
  - frame length constant = 11;
  - default `CLKS_PER_BIT`.
  - The transmitter uses the same constants.
- Sub-module `uart_sync2`: the 2-flop synchronizer with async active-low reset and a parameterized reset value (1 here).
- All other logic (FSM, bit counter, shift register, parity accumulator) lives in `uart_rx`.

## Test plan
- Clean frame 0xAC, even parity (parity bit 0, stop 1), N=16 -> `data_out` = 0xAC, `rx_done` pulses once at t0+H+10N+1, `parity_err` = 0, `frame_err` = 0.
- Same frame with the parity bit flipped to 1 -> `data_out` = 0xAC, `parity_err` = 1. A following clean frame 0x55 clears it to 0.
- Frame 0x3C with stop bit 0, `rx` held low for 3N, then high -> `rx_done` pulses with `frame_err` = 1. The FSM stays in BREAK until `rx` rises, then a frame 0x01 is received correctly.
- Low glitch on `rx` of N/4 cycles -> no `rx_done`, outputs unchanged, FSM back in IDLE.
- Reset pulse at data bit 4 of frame 0xFF -> outputs 0x00/0/0/0 and no `rx_done`. The next full frame 0x81 is received correctly.
- Back-to-back frames 0x00 and 0xFF with zero idle gap, with `PARITY_ODD` = 1 -> two `rx_done` pulses 11N apart, both `parity_err` = 0.
